// File: rtl/vblank_arbiter.sv
// Grants one shared resource to NREQ requesters, only inside the vblank window after vsync falls.
// Define VBLANK_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module vblank_arbiter #(
    parameter int NREQ       = 2,
    parameter int WIN_CYCLES = 29000
) (
    input  logic            px_clk,
    input  logic            rstn,
    input  logic            vsync,
    input  logic            activevideo,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            win_open,
    output logic            frame_tick,
    output logic [15:0]     frame_cnt,
    output logic            abort,
    output logic            overrun
);

    // state   | meaning
    // S_IDLE  | window closed, requests ignored
    // S_OPEN  | window open, no owner (also the forced gap after a release)
    // S_GRANT | window open, owner holds gnt while its req stays high
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPEN  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    localparam int          IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] WIN_RELOAD = 16'(WIN_CYCLES - 1);

    logic [1:0]       state;
    logic             vsync_d;
    logic [15:0]      win_cnt;
    logic [IDX_W-1:0] owner;
    logic             vs_fall;
    logic             win_close;
    logic             owner_req;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    assign vs_fall   = vsync_d & ~vsync;
    assign win_close = (win_cnt == 16'd0) | activevideo;
    assign owner_req = req[owner];

`ifdef VBLANK_ARB_RR_EN
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            win_open   <= 1'b0;
            gnt        <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= 16'd0;
            abort      <= 1'b0;
            overrun    <= 1'b0;
            vsync_d    <= 1'b1;
            win_cnt    <= 16'd0;
            owner      <= '0;
`ifdef VBLANK_ARB_RR_EN
            last       <= IDX_W'(NREQ - 1);
`endif
        end else begin
            vsync_d    <= vsync;
            frame_tick <= 1'b0;
            abort      <= 1'b0;
            if ((state != S_IDLE) && activevideo)
                overrun <= 1'b1;

            // A new vsync restarts the window even if one is still open.
            if (vs_fall) begin
                frame_tick <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
                win_cnt    <= WIN_RELOAD;
                state      <= S_OPEN;
                win_open   <= 1'b1;
                gnt        <= '0;
                if (state == S_GRANT) begin
                    abort <= 1'b1;
`ifdef VBLANK_ARB_RR_EN
                    last  <= owner;
`endif
                end
            end else if (state != S_IDLE) begin
                if (win_close) begin
                    state    <= S_IDLE;
                    win_open <= 1'b0;
                    gnt      <= '0;
                    if (state == S_GRANT) begin
                        abort <= owner_req;
`ifdef VBLANK_ARB_RR_EN
                        last  <= owner;
`endif
                    end
                end else begin
                    win_cnt <= win_cnt - 16'd1;
                    if ((state == S_OPEN) && pick_valid) begin
                        gnt   <= NREQ'(1) << pick_idx;
                        owner <= pick_idx;
                        state <= S_GRANT;
                    end else if ((state == S_GRANT) && !owner_req) begin
                        gnt   <= '0;
                        state <= S_OPEN;
`ifdef VBLANK_ARB_RR_EN
                        last  <= owner;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vblank_arbiter.sv
// Scoreboard bench for vblank_arbiter: a behavioural window/owner model predicts every cycle,
// a separate monitor compares DUT outputs against the queued predictions.
module tb_vblank_arbiter;

    localparam int NREQ = 2;
    localparam int WIN  = 20;

    logic            px_clk = 1'b0;
    logic            rstn   = 1'b1;
    logic            vsync  = 1'b1;
    logic            activevideo = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic            win_open;
    logic            frame_tick;
    logic [15:0]     frame_cnt;
    logic            abort;
    logic            overrun;

    vblank_arbiter #(.NREQ(NREQ), .WIN_CYCLES(WIN)) dut (
        .px_clk(px_clk), .rstn(rstn), .vsync(vsync), .activevideo(activevideo),
        .req(req), .gnt(gnt), .win_open(win_open), .frame_tick(frame_tick),
        .frame_cnt(frame_cnt), .abort(abort), .overrun(overrun)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            wo;
        logic            tick;
        logic [15:0]     fc;
        logic            ab;
        logic            ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: window as a remaining-cycle count, owner as an index (-1 = none)
    bit   m_prev_vs;
    bit   m_open;
    int   m_left;
    int   m_owner;
    int   m_last;
    int   m_frames;
    bit   m_overrun;

    logic            cur_vs  = 1'b1;
    logic            cur_av  = 1'b0;
    logic [NREQ-1:0] cur_req = '0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_prev_vs = 1'b1;
        m_open    = 1'b0;
        m_left    = 0;
        m_owner   = -1;
        m_last    = NREQ - 1;
        m_frames  = 0;
        m_overrun = 1'b0;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] rq);
`ifdef VBLANK_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (rq[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (rq[i]) return i;
`endif
        return -1;
    endfunction

    function automatic exp_t model_step(input logic vs, input logic av, input logic [NREQ-1:0] rq);
        exp_t e;
        bit   fall;
        fall      = m_prev_vs && !vs;
        m_prev_vs = vs;
        e.tick    = 1'b0;
        e.ab      = 1'b0;
        if (m_open && av) m_overrun = 1'b1;
        if (fall) begin
            if (m_owner >= 0) begin
                e.ab   = 1'b1;
                m_last = m_owner;
            end
            m_owner  = -1;
            m_open   = 1'b1;
            m_left   = WIN;
            m_frames = (m_frames + 1) % 65536;
            e.tick   = 1'b1;
        end else if (m_open) begin
            m_left--;
            if (m_left == 0 || av) begin
                if (m_owner >= 0) begin
                    e.ab   = rq[m_owner];
                    m_last = m_owner;
                end
                m_owner = -1;
                m_open  = 1'b0;
            end else if (m_owner < 0) begin
                m_owner = pick(rq);
            end else if (!rq[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        e.gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        e.wo  = m_open;
        e.fc  = 16'(m_frames);
        e.ov  = m_overrun;
        return e;
    endfunction

    task automatic step();
        @(negedge px_clk);
        vsync       = cur_vs;
        activevideo = cur_av;
        req         = cur_req;
        sb_q.push_back(model_step(cur_vs, cur_av, cur_req));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic vs_pulse();
        cur_vs = 1'b0;
        run(2);
        cur_vs = 1'b1;
    endtask

    // monitor: compare whatever the DUT presents after each edge against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge px_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("gnt",        16'(gnt),        16'(e.gnt));
                check("win_open",   16'(win_open),   16'(e.wo));
                check("frame_tick", 16'(frame_tick), 16'(e.tick));
                check("frame_cnt",  frame_cnt,       e.fc);
                check("abort",      16'(abort),      16'(e.ab));
                check("overrun",    16'(overrun),    16'(e.ov));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int frame_left;
        model_reset();
        #2 rstn = 1'b0;
        #2;
        check("rst_gnt",       16'(gnt),        16'd0);
        check("rst_win_open",  16'(win_open),   16'd0);
        check("rst_tick",      16'(frame_tick), 16'd0);
        check("rst_frame_cnt", frame_cnt,       16'd0);
        check("rst_abort",     16'(abort),      16'd0);
        check("rst_overrun",   16'(overrun),    16'd0);
        repeat (3) @(negedge px_clk);
        rstn = 1'b1;

        // window length and tick/count with no requests
        run(3);
        vs_pulse();
        run(25);

        // both request; release/re-request exercises the gap and arbitration order
        vs_pulse();
        cur_req = 2'b11; run(4);
        cur_req = 2'b10; run(3);
        cur_req = 2'b11; run(3);
        cur_req = 2'b00; run(20);

        // owner holds through the close: abort, no overrun
        vs_pulse();
        cur_req = 2'b01; run(25);
        cur_req = 2'b00; run(3);

        // activevideo during a grant: early close, abort, sticky overrun
        vs_pulse();
        cur_req = 2'b01; run(3);
        cur_av  = 1'b1;  run(1);
        cur_av  = 1'b0;  run(5);
        cur_req = 2'b00; run(20);

        // request only while idle, then a window opens
        cur_req = 2'b10; run(5);
        vs_pulse();
        run(6);
        cur_req = 2'b00; run(20);

        // frame counter wrap
        @(posedge px_clk);
        #2 force dut.frame_cnt = 16'hffff;
        #1 release dut.frame_cnt;
        m_frames = 16'hffff;
        vs_pulse();
        run(22);

        // randomized frames, requests and rare activevideo
        frame_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (frame_left == 0) frame_left = $urandom_range(12, 45);
            frame_left--;
            cur_vs = (frame_left < 2) ? 1'b0 : 1'b1;
            cur_av = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) == 0) cur_req[i] = ~cur_req[i];
            step();
        end

        // asynchronous reset while granted
        cur_vs = 1'b1; cur_av = 1'b0; cur_req = 2'b00;
        run(50);
        vs_pulse();
        cur_req = 2'b01; run(3);
        @(posedge px_clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_gnt",       16'(gnt),       16'd0);
        check("arst_win_open",  16'(win_open),  16'd0);
        check("arst_frame_cnt", frame_cnt,      16'd0);
        check("arst_abort",     16'(abort),     16'd0);
        check("arst_overrun",   16'(overrun),   16'd0);
        #1 rstn = 1'b1;
        model_reset();
        cur_req = 2'b00;
        run(3);
        vs_pulse();
        cur_req = 2'b10; run(6);
        cur_req = 2'b00; run(22);

        @(posedge px_clk);
        #3;
        check("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
